// File: rtl/ccip_mmio_initiator.sv
// ccip_mmio_initiator: host-side CCI-P MMIO requester.
// Turns read/write commands into one-cycle Rx c0 MMIO strobes. Read
// responses are matched on Tx c2 by tid, and the result is reported back
// on the command side.
// Optional feature: define CCIP_MMIO_INIT_TIMEOUT_EN to give up on a read
// after TIMEOUT_CYC cycles. Without it, WAIT holds until a matching
// response arrives or rst is asserted.
// Command handshake: a command transfers on a cycle where cmd_valid and
// cmd_ready are both high. rsp_valid is a one-cycle pulse with no ready.
module ccip_mmio_initiator #(
    parameter int ADDR_W      = 16,
    parameter int TID_W       = 9,
    parameter int TIMEOUT_CYC = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [63:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mmio_wr_valid,
    output logic              mmio_rd_valid,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [TID_W-1:0]  mmio_tid,
    output logic [63:0]       mmio_wdata,
    input  logic              c2_rd_valid,
    input  logic [TID_W-1:0]  c2_tid,
    input  logic [63:0]       c2_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_RESP = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TID_W-1:0]  tid;
    logic [15:0]       stray_cnt;
    logic              c2_match;
    logic              expired;

    assign c2_match = c2_rd_valid && (c2_tid == tid);

`ifdef CCIP_MMIO_INIT_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] timer;

    assign expired = (timer == TMR_W'(TIMEOUT_CYC - 1));

    // Response timer: cleared while the read strobe is out, counts during WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state == S_RD) begin
            timer <= '0;
        end else if (state == S_WAIT) begin
            timer <= timer + TMR_W'(1);
        end
    end
`else
    assign expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A matching response beats timer expiry in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_addr[0]) begin
                        state_next = S_ERR;
                    end else if (cmd_wr) begin
                        state_next = S_WR;
                    end else begin
                        state_next = S_RD;
                    end
                end
            end
            S_WR:   state_next = S_RESP;
            S_RD:   state_next = S_WAIT;
            S_WAIT: begin
                if (c2_match) begin
                    state_next = S_RESP;
                end else if (expired) begin
                    state_next = S_ERR;
                end
            end
            S_RESP: state_next = S_IDLE;
            S_ERR:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Registered outputs, decoded from the next state. The MMIO address and
    // data registers double as the command latch, and read zero outside a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_rdata     <= '0;
            mmio_wr_valid <= 1'b0;
            mmio_rd_valid <= 1'b0;
            mmio_addr     <= '0;
            mmio_tid      <= '0;
            mmio_wdata    <= '0;
        end else begin
            cmd_ready     <= (state_next == S_IDLE);
            rsp_valid     <= (state_next == S_RESP) || (state_next == S_ERR);
            rsp_err       <= (state_next == S_ERR);
            mmio_wr_valid <= (state_next == S_WR);
            mmio_rd_valid <= (state_next == S_RD);
            mmio_addr     <= ((state_next == S_WR) || (state_next == S_RD)) ? cmd_addr : '0;
            mmio_tid      <= (state_next == S_RD) ? tid : '0;
            mmio_wdata    <= (state_next == S_WR) ? cmd_wdata : '0;
            if (state_next == S_ERR) begin
                rsp_rdata <= 64'hFFFF_FFFF_FFFF_FFFF;
            end else if ((state == S_WAIT) && c2_match) begin
                rsp_rdata <= c2_data;
            end else begin
                rsp_rdata <= '0;
            end
        end
    end

    // The transaction ID advances once per finished read, whether it matched or
    // timed out. The stray counter saturates on unmatched responses seen in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tid       <= '0;
            stray_cnt <= '0;
        end else if (state == S_WAIT) begin
            if (c2_match || expired) begin
                tid <= tid + TID_W'(1);
            end
            if (c2_rd_valid && !c2_match && (stray_cnt != 16'hFFFF)) begin
                stray_cnt <= stray_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ccip_mmio_initiator.sv
// tb_ccip_mmio_initiator: directed bench for ccip_mmio_initiator.
// Drivers push the expected MMIO strobes and responses, each with its
// cycle number, into queues. One compare process checks the DUT outputs
// against these queues on every negative clock edge.
module tb_ccip_mmio_initiator;

    localparam int ADDR_W      = 16;
    localparam int TID_W       = 9;
    localparam int TIMEOUT_CYC = 512;
    localparam int BIG         = 32'h7fff_ffff;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_wr = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [63:0]       cmd_wdata = '0;
    logic              rsp_valid;
    logic [63:0]       rsp_rdata;
    logic              rsp_err;
    logic              mmio_wr_valid;
    logic              mmio_rd_valid;
    logic [ADDR_W-1:0] mmio_addr;
    logic [TID_W-1:0]  mmio_tid;
    logic [63:0]       mmio_wdata;
    logic              c2_rd_valid = 1'b0;
    logic [TID_W-1:0]  c2_tid = '0;
    logic [63:0]       c2_data = '0;

    ccip_mmio_initiator #(
        .ADDR_W      (ADDR_W),
        .TID_W       (TID_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_wr        (cmd_wr),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mmio_wr_valid (mmio_wr_valid),
        .mmio_rd_valid (mmio_rd_valid),
        .mmio_addr     (mmio_addr),
        .mmio_tid      (mmio_tid),
        .mmio_wdata    (mmio_wdata),
        .c2_rd_valid   (c2_rd_valid),
        .c2_tid        (c2_tid),
        .c2_data       (c2_data)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model state ----------------
    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [8:0]  tid;
        logic [63:0] data;
    } req_t;

    typedef struct {
        int          cyc;
        logic        err;
        logic [63:0] data;
    } rsp_t;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];
    req_t er;
    rsp_t es;

    int   n_checks = 0;
    int   n_pass = 0;
    int   model_tid = 0;
    int   model_stray = 0;
    int   busy_from = 0;
    int   free_from = 0;
    logic checking = 1'b0;

    int          last_rsp_cyc = -1;
    logic        last_rsp_err = 1'b0;
    logic [63:0] last_rsp_data = '0;
    logic [63:0] last_wr_data = '0;
    logic [8:0]  last_rd_tid = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (checking && !rst) begin
            check("cmd_ready", 64'(cmd_ready), 64'(!(cyc >= busy_from && cyc < free_from)));
            if (mmio_wr_valid && mmio_rd_valid) fail_now("strobe_overlap", "wr and rd strobes both high");
            if (mmio_wr_valid || mmio_rd_valid) begin
                if (exp_req_q.size() == 0) begin
                    fail_now("unexpected_req", "MMIO strobe with none expected");
                end else begin
                    er = exp_req_q.pop_front();
                    check("req_cycle", 64'(cyc), 64'(er.cyc));
                    check("req_wr", 64'(mmio_wr_valid), 64'(er.wr));
                    check("req_addr", 64'(mmio_addr), 64'(er.addr));
                    if (er.wr) begin
                        check("req_wdata", mmio_wdata, er.data);
                        last_wr_data = mmio_wdata;
                    end else begin
                        check("req_tid", 64'(mmio_tid), 64'(er.tid));
                        last_rd_tid = mmio_tid;
                    end
                end
            end else if (exp_req_q.size() != 0 && exp_req_q[0].cyc <= cyc) begin
                fail_now("missing_req", "expected MMIO strobe did not appear");
                void'(exp_req_q.pop_front());
            end
            if (rsp_valid) begin
                last_rsp_cyc  = cyc;
                last_rsp_err  = rsp_err;
                last_rsp_data = rsp_rdata;
                if (exp_rsp_q.size() == 0) begin
                    fail_now("unexpected_rsp", "rsp_valid with none expected");
                end else begin
                    es = exp_rsp_q.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(es.cyc));
                    check("rsp_err", 64'(rsp_err), 64'(es.err));
                    check("rsp_rdata", rsp_rdata, es.data);
                end
            end else if (exp_rsp_q.size() != 0 && exp_rsp_q[0].cyc <= cyc) begin
                fail_now("missing_rsp", "expected rsp_valid did not appear");
                void'(exp_rsp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_neg(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    // Present one command. Once it is accepted, push what the spec says must follow.
    task automatic send(input logic wr, input logic [15:0] addr, input logic [63:0] data,
                        input logic to, output int h);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) fail_now("handshake_timeout", "cmd_ready never rose");
        h = cyc;
        busy_from = h + 1;
        if (addr[0]) begin
            exp_rsp_q.push_back('{h + 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
            free_from = h + 2;
        end else if (wr) begin
            exp_req_q.push_back('{h + 1, 1'b1, addr, 9'd0, data});
            exp_rsp_q.push_back('{h + 2, 1'b0, 64'd0});
            free_from = h + 3;
        end else begin
            exp_req_q.push_back('{h + 1, 1'b0, addr, 9'(model_tid), 64'd0});
            free_from = BIG;
            if (to) begin
                exp_rsp_q.push_back('{h + 1 + TIMEOUT_CYC + 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
                free_from = h + 1 + TIMEOUT_CYC + 2;
                model_tid = (model_tid + 1) % 512;
            end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // One cycle of Tx c2 traffic. kind: 1 = matching response, 0 = stray seen in WAIT,
    // 2 = arrives outside WAIT and must be ignored.
    task automatic c2_send(input logic [8:0] tid, input logic [63:0] data, input int kind);
        c2_rd_valid = 1'b1;
        c2_tid      = tid;
        c2_data     = data;
        if (kind == 1) begin
            exp_rsp_q.push_back('{cyc + 1, 1'b0, data});
            free_from = cyc + 2;
            model_tid = (model_tid + 1) % 512;
        end else if (kind == 0) begin
            model_stray++;
        end
        @(negedge clk);
        c2_rd_valid = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [63:0] data, input int d);
        int h;
        send(1'b0, addr, 64'd0, 1'b0, h);
        wait_neg(h + 1 + d);
        c2_send(9'(model_tid), data, 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        fail_now("watchdog", "simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int h;
        int r;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_mmio_wr_valid", 64'(mmio_wr_valid), 64'd0);
        check("rst_mmio_rd_valid", 64'(mmio_rd_valid), 64'd0);
        check("rst_mmio_addr", 64'(mmio_addr), 64'd0);
        check("rst_mmio_tid", 64'(mmio_tid), 64'd0);
        check("rst_mmio_wdata", mmio_wdata, 64'd0);
        rst = 1'b0;
        checking = 1'b1;

        // Posted write.
        send(1'b1, 16'h0020, 64'h0123_4567_89AB_CDEF, 1'b0, h);
        wait_neg(h + 3);
        check("wr_latency", 64'(last_rsp_cyc - h), 64'd2);
        check("wr_strobe_data", last_wr_data, 64'h0123_4567_89AB_CDEF);

        // Read DFH. The response comes three cycles after the request, with tid 0.
        send(1'b0, 16'h0000, 64'd0, 1'b0, h);
        r = h + 1;
        wait_neg(r + 3);
        c2_send(9'd0, 64'h1000_0100_0000_0000, 1);
        wait_neg(r + 5);
        check("rd0_tid", 64'(last_rd_tid), 64'd0);
        check("rd0_data", last_rsp_data, 64'h1000_0100_0000_0000);

        // A stray tid is ignored, then the correct tid (1) completes the read.
        send(1'b0, 16'h0002, 64'd0, 1'b0, h);
        r = h + 1;
        wait_neg(r + 1);
        c2_send(9'd5, 64'h1234, 0);
        wait_neg(r + 3);
        c2_send(9'(model_tid), 64'hAAAA, 1);
        wait_neg(r + 5);
        check("rd1_tid", 64'(last_rd_tid), 64'd1);
        check("stray_data", last_rsp_data, 64'hAAAA);
        check("stray_cnt", 64'(dut.stray_cnt), 64'(model_stray));
        check("stray_cnt_lit", 64'(dut.stray_cnt), 64'd1);

`ifdef CCIP_MMIO_INIT_TIMEOUT_EN
        // No responder: an error comes back TIMEOUT_CYC+1 cycles after the request.
        send(1'b0, 16'h0004, 64'd0, 1'b1, h);
        r = h + 1;
        wait_neg(r + TIMEOUT_CYC + 3);
        check("timeout_latency", 64'(last_rsp_cyc - r), 64'd513);
        check("timeout_err", 64'(last_rsp_err), 64'd1);
        check("timeout_data", last_rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        // No timer: WAIT holds well past TIMEOUT_CYC, then a late match completes it.
        send(1'b0, 16'h0004, 64'd0, 1'b0, h);
        r = h + 1;
        wait_neg(r + TIMEOUT_CYC + 50);
        check("no_timeout_rsp", 64'(last_rsp_cyc < r), 64'd1);
        c2_send(9'(model_tid), 64'h55, 1);
        wait_neg(r + TIMEOUT_CYC + 52);
        check("late_match_data", last_rsp_data, 64'h55);
        check("late_match_err", 64'(last_rsp_err), 64'd0);
`endif

        // A misaligned command issues no strobe and returns an error in the next cycle.
        send(1'b0, 16'h0021, 64'd0, 1'b0, h);
        wait_neg(h + 2);
        check("misalign_latency", 64'(last_rsp_cyc - h), 64'd1);
        check("misalign_err", 64'(last_rsp_err), 64'd1);
        check("misalign_tid_kept", 64'(model_tid), 64'd3);

        // Step the tid up to 511 with quick reads, then wrap it.
        while (model_tid != 511) do_read(16'(32 + 2 * (model_tid % 16)), 64'(model_tid) << 8, 1);
        do_read(16'h0030, 64'hCAFE, 2);
        check("wrap_tid_511", 64'(last_rd_tid), 64'd511);

        // Read with tid 0 after the wrap, then assert reset while in WAIT.
        send(1'b0, 16'h0040, 64'd0, 1'b0, h);
        r = h + 1;
        wait_neg(r + 2);
        check("wrapped_tid_0", 64'(last_rd_tid), 64'd0);
        rst = 1'b1;
        exp_req_q.delete();
        exp_rsp_q.delete();
        model_tid = 0;
        model_stray = 0;
        busy_from = 0;
        free_from = 0;
        #1;
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_rd_valid", 64'(mmio_rd_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        c2_send(9'd0, 64'hBAD0_BAD0, 2);
        repeat (4) @(negedge clk);
        check("late_rsp_no_stray", 64'(dut.stray_cnt), 64'd0);

        // After reset the next read uses tid 0 again.
        do_read(16'h0002, 64'hDEAD_BEEF, 2);
        repeat (3) @(negedge clk);
        check("post_rst_tid", 64'(last_rd_tid), 64'd0);
        check("post_rst_data", last_rsp_data, 64'hDEAD_BEEF);

        repeat (4) @(negedge clk);
        check("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
        check("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
